vram_arbiter: RTL and testbench

Shares the single video-memory port between several bus masters, for example the CPU, a DMA/init sequencer and a debug loader. Each master gets a valid/ready request channel. A round-robin scheduler with burst lock picks one master per cycle and drives one registered memory access. Writes into the video region (sprite/BG params, map, tiles, palettes at 0x06xx_xxxx) can be restricted to vertical blank. Sits between the masters and the video memory block, in place of the direct `mem_*` connection.

---
 rtl/gameconsole_pkg.sv | 29 ++
 rtl/vram_arbiter_if.sv | 26 ++
 rtl/vram_arbiter_rr.sv | 70 +++++++
 rtl/vram_arbiter.sv | 113 +++++++++++
 tb/tb_vram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gameconsole_pkg.sv
// Shared address map and helper types for the game-console memory system.
// The video region holds sprite/BG parameters, the BG map, tile data and
// palettes; the arbiter uses the region decode to gate writes to vblank.
package gameconsole_pkg;

  localparam logic [31:0] VIDEO_BASE     = 32'h0600_0000;
  localparam logic [31:0] VIDEO_MASK     = 32'hFF00_0000;

  localparam logic [31:0] PARAM_BASE     = 32'h0600_0000;
  localparam logic [31:0] MAP_BASE       = 32'h0610_0000;
  localparam logic [31:0] TILE_BASE      = 32'h0620_0000;
  localparam logic [31:0] TILE_HI_BASE   = 32'h0621_0000;
  localparam logic [31:0] PALETTE_BASE   = 32'h0630_0000;

  // One memory access as selected from the granted master.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // True when addr falls inside the region described by base/mask.
  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Request bus between the bus masters and the video-memory arbiter.
// Address and write data are packed 32 bits per master, master i at
// bits [32i+31:32i]; read data is shared and qualified by req_rvalid.
interface vram_arbiter_if #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_rvalid;
  logic [31:0]           req_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, req_rvalid, req_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, req_rvalid, req_rdata
  );

endinterface

// File: rtl/vram_arbiter_rr.sv
// Round-robin scheduler with burst lock. The search for a winner starts at
// ptr and wraps; ptr parks on the current owner until it has taken
// BURST_MAX consecutive beats, then moves one past it.
module rr_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int BURST_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_nxt;
  logic             found;
  int               pos;

  // First eligible master at or after ptr, modulo NUM_REQ.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IDX_W'(pos);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  // Beat count after this accept: continue the owner's run or start a new one.
  always_comb begin
    beat_nxt = CNT_W'(1);
    if (gidx == owner && beat_cnt != '0) beat_nxt = beat_cnt + 1'b1;
  end

  // Pointer/burst state advances only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      owner <= gidx;
      if (beat_nxt == CNT_W'(BURST_MAX)) begin
        ptr      <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        beat_cnt <= '0;
      end else begin
        ptr      <= gidx;
        beat_cnt <= beat_nxt;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Video-memory port arbiter: decodes per-master eligibility (video-region
// writes wait for vblank), picks one master per cycle through rr_arbiter,
// registers the winning access onto mem_* and returns read data two cycles
// after the accept with a per-master rvalid pulse.
module vram_arbiter #(
  parameter int          NUM_REQ     = 3,
  parameter int          BURST_MAX   = 16,
  parameter bit          VBLANK_ONLY = 1'b1,
  parameter logic [31:0] VIDEO_BASE  = gameconsole_pkg::VIDEO_BASE,
  parameter logic [31:0] VIDEO_MASK  = gameconsole_pkg::VIDEO_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vblank,
  vram_arbiter_if.slave        bus,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout
);

  import gameconsole_pkg::*;

  logic [NUM_REQ-1:0] blocked;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  mem_req_t           sel;
  logic [NUM_REQ-1:0] rd_vld_p0;
  logic [NUM_REQ-1:0] rd_vld_p1;

  // A master is held off only for a video-region write outside vblank.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      blocked[i] = VBLANK_ONLY && bus.req_we[i] && !vblank &&
                   in_region(bus.req_addr[32*i +: 32], VIDEO_BASE, VIDEO_MASK);
    end
    eligible = bus.req_valid & ~blocked;
  end

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .BURST_MAX (BURST_MAX)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .eligible (eligible),
    .accept   (accept),
    .grant    (grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |(bus.req_valid & grant);

  // Mux the granted master's request (grant is one-hot or zero).
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.we    = bus.req_we[i];
        sel.addr  = bus.req_addr[32*i +: 32];
        sel.wdata = bus.req_wdata[32*i +: 32];
      end
    end
  end

  // Accept edge -> memory command register; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & sel.we;
      if (accept) begin
        mem_addr <= sel.addr;
        mem_din  <= sel.wdata;
      end
    end
  end

  // Read-return pipeline: p0 tracks the cycle mem_* is presented,
  // p1 the cycle mem_dout is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p0 <= '0;
      rd_vld_p1 <= '0;
    end else begin
      // stage p0: capture the reader at the accept edge
      rd_vld_p0 <= (accept && !sel.we) ? grant : '0;
      // stage p1: aligned with the synchronous memory read
      rd_vld_p1 <= rd_vld_p0;
    end
  end

  assign bus.req_rvalid = rd_vld_p1;
  assign bus.req_rdata  = mem_dout;

  // Masters must not change a pending request while it waits for ready.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
      (bus.req_valid[i] && !bus.req_ready[i]) |=>
        (!bus.req_valid[i] ||
         ($stable(bus.req_we[i]) &&
          $stable(bus.req_addr[32*i +: 32]) &&
          $stable(bus.req_wdata[32*i +: 32]))));
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: hand sequences, a table of arbitration
// vectors and a random soak, with a read-return scoreboard.
module tb_vram_arbiter;

  localparam int N   = 3;
  localparam int BM  = 16;
  localparam int LIM = (N - 1) * BM;

  logic        clk;
  logic        rst;
  logic        vblank;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit soak_on = 1'b0;

  vram_arbiter_if #(.NUM_REQ(N)) bus ();

  vram_arbiter #(
    .NUM_REQ     (N),
    .BURST_MAX   (BM),
    .VBLANK_ONLY (1'b1),
    .VIDEO_BASE  (32'h0600_0000),
    .VIDEO_MASK  (32'hFF00_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vblank   (vblank),
    .bus      (bus),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 5) return 32'h0000_00AB;
    return 32'hA500_0000 + 32'(idx) * 32'h0001_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: 1-cycle synchronous read; unwritten words read init_word.
  logic [31:0] ram    [256];
  logic        ram_wr [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_wr[i] <= 1'b0;
      mem_dout <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[7:0]]    <= mem_din;
        ram_wr[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_dout <= ram_wr[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_word(int'(mem_addr[7:0]));
      end
    end
  end

  // Scoreboard: expected read returns queued at accept, popped at rvalid.
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t        q[$];
  logic [31:0] sh     [256];
  logic        sh_wr  [256];
  int          wcnt   [N];
  exp_t        e;
  logic [31:0] a;
  logic [N-1:0] blk;
  logic [N-1:0] elig;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      for (int i = 0; i < 256; i++) sh_wr[i] = 1'b0;
      for (int i = 0; i < N; i++) wcnt[i] = 0;
    end else begin
      if (bus.req_rvalid != '0) begin
        if (q.size() == 0) begin
          check("rvalid_unexpected", 32'(bus.req_rvalid), 32'h0);
        end else begin
          e = q.pop_front();
          check("rvalid_id", 32'(bus.req_rvalid), 32'h1 << e.id);
          check("rdata", bus.req_rdata, e.data);
          check("rvalid_latency", cyc, e.due);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          a = bus.req_addr[32*i +: 32];
          if (bus.req_we[i]) begin
            sh[a[7:0]]    = bus.req_wdata[32*i +: 32];
            sh_wr[a[7:0]] = 1'b1;
          end else begin
            q.push_back('{i, sh_wr[a[7:0]] ? sh[a[7:0]] : init_word(int'(a[7:0])), cyc + 2});
          end
        end
      end
      if (soak_on) begin
        for (int i = 0; i < N; i++)
          blk[i] = bus.req_we[i] && !vblank && (bus.req_addr[32*i+24 +: 8] == 8'h06);
        elig = bus.req_valid & ~blk;
        check("soak_onehot", 32'($onehot0(bus.req_ready)), 32'h1);
        check("soak_ready_eligible", 32'(bus.req_ready & ~elig), 32'h0);
        if (elig != '0) check("soak_no_bubble", 32'(|bus.req_ready), 32'h1);
        for (int i = 0; i < N; i++) begin
          if (bus.req_valid[i] && !bus.req_ready[i] && !blk[i]) wcnt[i]++;
          else wcnt[i] = 0;
          if (wcnt[i] > LIM) check("soak_starvation", 32'(wcnt[i]), 32'(LIM));
        end
      end else begin
        for (int i = 0; i < N; i++) wcnt[i] = 0;
      end
    end
  end

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] we;
    logic [N-1:0] vid;
    logic         vb;
    logic [N-1:0] exp;
  } row_t;
  row_t tbl [15];

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] ad, input logic [31:0] wd);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[32*i +: 32]  = ad;
    bus.req_wdata[32*i +: 32] = wd;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] acc;
  logic [N-1:0] prev_exp;
  logic [N-1:0] prev_we;

  initial begin
    tbl[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b001};
    tbl[2]  = '{3'b110, 3'b000, 3'b000, 1'b0, 3'b010};
    tbl[3]  = '{3'b101, 3'b000, 3'b000, 1'b0, 3'b100};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 1'b0, 3'b001};
    tbl[5]  = '{3'b010, 3'b010, 3'b010, 1'b0, 3'b000};
    tbl[6]  = '{3'b010, 3'b010, 3'b010, 1'b1, 3'b010};
    tbl[7]  = '{3'b111, 3'b111, 3'b111, 1'b0, 3'b000};
    tbl[8]  = '{3'b111, 3'b111, 3'b111, 1'b1, 3'b010};
    tbl[9]  = '{3'b101, 3'b101, 3'b101, 1'b0, 3'b000};
    tbl[10] = '{3'b101, 3'b101, 3'b101, 1'b1, 3'b100};
    tbl[11] = '{3'b011, 3'b001, 3'b011, 1'b0, 3'b010};
    tbl[12] = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b001};
    tbl[13] = '{3'b001, 3'b001, 3'b000, 1'b0, 3'b001};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000};

    rst           = 1'b1;
    vblank        = 1'b0;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    @(negedge clk);
    check("idle_mem_en", 32'(mem_en), 32'h0);
    check("idle_mem_we", 32'(mem_we), 32'h0);
    check("idle_mem_addr", mem_addr, 32'h0);
    check("idle_mem_din", mem_din, 32'h0);
    check("idle_ready", 32'(bus.req_ready), 32'h0);
    check("idle_rvalid", 32'(bus.req_rvalid), 32'h0);

    // Read latency
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h0610_0005, 32'h0);
    @(negedge clk);
    check("lat_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("lat_mem_en", 32'(mem_en), 32'h1);
    check("lat_mem_we", 32'(mem_we), 32'h0);
    check("lat_mem_addr", mem_addr, 32'h0610_0005);
    check("lat_rvalid_early", 32'(bus.req_rvalid), 32'h0);
    @(negedge clk);
    check("lat_rvalid", 32'(bus.req_rvalid), 32'h1);
    check("lat_rdata", bus.req_rdata, 32'h0000_00AB);

    // Burst rotation between masters 0 and 1
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h0200_0010, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0200_0011, 32'h0);
    for (int k = 0; k < 4 * BM; k++) begin
      @(negedge clk);
      check("burst_grant", 32'(bus.req_ready), ((k / BM) % 2 == 0) ? 32'h1 : 32'h2);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;

    // Vblank gating
    do_reset();
    @(posedge clk); #1;
    vblank = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h0600_0000, 32'h1234_5678);
    set_req(2, 1'b1, 1'b0, 32'h0200_0020, 32'h0);
    @(negedge clk);
    check("vb_only_reader", 32'(bus.req_ready), 32'h4);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check("vb_still_blocked", 32'(bus.req_ready), 32'h0);
    check("vb_read_mem_en", 32'(mem_en), 32'h1);
    check("vb_read_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk); #1;
    vblank = 1'b1;
    @(negedge clk);
    check("vb_write_granted", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    bus.req_valid = '0;
    vblank = 1'b0;
    @(negedge clk);
    check("vb_mem_en", 32'(mem_en), 32'h1);
    check("vb_mem_we", 32'(mem_we), 32'h1);
    check("vb_mem_addr", mem_addr, 32'h0600_0000);
    check("vb_mem_din", mem_din, 32'h1234_5678);

    // Table of arbitration vectors
    do_reset();
    prev_exp = '0;
    prev_we  = '0;
    for (int r = 0; r < 15; r++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        set_req(i, tbl[r].v[i], tbl[r].we[i],
                (tbl[r].vid[i] ? 32'h0600_0000 : 32'h0200_0000) + 32'(i),
                32'hD000_0000 + 32'(i));
      vblank = tbl[r].vb;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].exp));
      check($sformatf("tbl%0d_mem_en", r), 32'(mem_en), 32'(|prev_exp));
      check($sformatf("tbl%0d_mem_we", r), 32'(mem_we), 32'(|(prev_exp & prev_we)));
      prev_exp = tbl[r].exp;
      prev_we  = tbl[r].we;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    vblank = 1'b0;

    // Reset in the cycle after a read accept
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h0200_0003, 32'h0);
    @(negedge clk);
    check("rst_rd_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_async_mem_en", 32'(mem_en), 32'h0);
    check("rst_async_mem_addr", mem_addr, 32'h0);
    check("rst_async_rvalid", 32'(bus.req_rvalid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_rvalid", 32'(bus.req_rvalid), 32'h0);
    end

    // Random soak
    do_reset();
    soak_on = 1'b1;
    acc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0 ? 32'h0600_0000 : 32'h0200_0000) +
                    32'($urandom_range(0, 15)), $urandom);
          else
            bus.req_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
    end
    @(posedge clk); #1;
    soak_on = 1'b0;
    bus.req_valid = '0;
    vblank = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
